// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: input synchronizers, button debouncers, RUN/PAUSED/ADJ
// mode FSM and all timing strobes (run tick, adjust step, blink, display scan), all
// derived as single-cycle enables from the one system clock.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int DEB_LEN   = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       run_inc_o,
    output logic       adj_sec_o,
    output logic       adj_min_o,
    output logic       clr_o,
    output logic       blink_on,
    output logic       blink_sel,
    output logic [1:0] digit_sel,
    output logic [1:0] state_o
);
    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int DW = (DEB_LEN   > 1) ? $clog2(DEB_LEN)   : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_LEN - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_ADJ    = 2'b10
    } state_t;

    // Bit order: {sel, adj, clr, pause}
    logic [3:0]         r_sync1, r_sync2;
    logic [1:0][DW-1:0] r_deb_cnt;
    logic [1:0]         r_acc, r_acc_q;
    logic               w_pause_s, w_clr_s, w_adj_s, w_sel_s;
    logic               w_pause_evt, w_clr_evt;

    state_t             r_state, w_state_nxt;
    logic               r_saved_run, w_saved_nxt;
    logic               w_adj_entry;

    logic [TW-1:0]      r_run_cnt;
    logic [AW-1:0]      r_adj_cnt;
    logic [BW-1:0]      r_blink_cnt;
    logic               r_blink;
    logic [SW-1:0]      r_scan_cnt;
    logic [1:0]         r_digit;
    logic               r_clr;
    logic               w_run_inc, w_adj_sec, w_adj_min;

    // Two-stage synchronizers on every asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw_sel, sw_adj, btn_clr, btn_pause};
            r_sync2 <= r_sync1;
        end
    end

    assign w_pause_s = r_sync2[0];
    assign w_clr_s   = r_sync2[1];
    assign w_adj_s   = r_sync2[2];
    assign w_sel_s   = r_sync2[3];

    // Debounce: a new level is accepted only after DEB_LEN consecutive differing samples;
    // falling back to the accepted level restarts the count, so short bursts are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= '0;
            r_acc     <= '0;
            r_acc_q   <= '0;
        end else begin
            r_acc_q <= r_acc;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_acc[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_acc[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Only the press (rising accepted level) produces an event; release is silent
    assign w_pause_evt = r_acc[0] & ~r_acc_q[0];
    assign w_clr_evt   = r_acc[1] & ~r_acc_q[1];

    // Mode state register and remembered run/pause mode for leaving ADJ
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_saved_run <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_saved_run <= w_saved_nxt;
        end
    end

    // Next-state logic (adj switch wins over a pause press) and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved_run;
        w_run_inc   = 1'b0;
        w_adj_sec   = 1'b0;
        w_adj_min   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_adj_s) begin
                    w_state_nxt = ST_ADJ;
                    w_saved_nxt = 1'b1;
                end else if (w_pause_evt) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (w_adj_s) begin
                    w_state_nxt = ST_ADJ;
                    w_saved_nxt = 1'b0;
                end else if (w_pause_evt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ADJ: begin
                if (!w_adj_s) begin
                    w_state_nxt = r_saved_run ? ST_RUN : ST_PAUSED;
                end else if (w_pause_evt) begin
                    w_saved_nxt = ~r_saved_run;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
        // A clear in flight owns the cycle; any coincident count strobe is dropped
        if (!r_clr) begin
            if (r_state == ST_RUN && r_run_cnt == TICK_LAST) begin
                w_run_inc = 1'b1;
            end
            if (r_state == ST_ADJ && r_adj_cnt == ADJ_LAST) begin
                w_adj_sec = w_sel_s;
                w_adj_min = ~w_sel_s;
            end
        end
    end

    assign w_adj_entry = (r_state != ST_ADJ) && (w_state_nxt == ST_ADJ);

    // Run divider: advances only in RUN so a pause keeps its phase; clear restarts it
    always_ff @(posedge clk) begin
        if (rst || r_clr) begin
            r_run_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_run_cnt <= (r_run_cnt == TICK_LAST) ? '0 : r_run_cnt + TW'(1);
        end
    end

    // Adjust step and blink timers: restarted on ADJ entry, running only in ADJ
    always_ff @(posedge clk) begin
        if (rst || w_adj_entry) begin
            r_adj_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_state == ST_ADJ) begin
            r_adj_cnt <= (r_adj_cnt == ADJ_LAST) ? '0 : r_adj_cnt + AW'(1);
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Clear strobe lands one cycle after the debounced press, regardless of mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr <= 1'b0;
        end else begin
            r_clr <= w_clr_evt;
        end
    end

    // Free-running display scan, independent of mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    assign run_inc_o = w_run_inc;
    assign adj_sec_o = w_adj_sec;
    assign adj_min_o = w_adj_min;
    assign clr_o     = r_clr;
    assign blink_on  = (r_state != ST_ADJ) || r_blink;
    assign blink_sel = w_sel_s;
    assign digit_sel = r_digit;
    assign state_o   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with small dividers. Expected strobes are queued with
// the cycle they must appear in and matched against DUT output every cycle.
module tb_stopwatch_ctrl;
    localparam logic [1:0] ST_R = 2'b00;
    localparam logic [1:0] ST_P = 2'b01;
    localparam logic [1:0] ST_A = 2'b10;
    // strobe kind bits: {clr, adj_min, adj_sec, run_inc}
    localparam logic [3:0] K_RUN = 4'b0001;
    localparam logic [3:0] K_SEC = 4'b0010;
    localparam logic [3:0] K_MIN = 4'b0100;
    localparam logic [3:0] K_CLR = 4'b1000;

    logic       clk = 1'b0;
    logic       rst, btn_pause, btn_clr, sw_adj, sw_sel;
    logic       run_inc_o, adj_sec_o, adj_min_o, clr_o, blink_on, blink_sel;
    logic [1:0] digit_sel, state_o;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   r0, r1;

    stopwatch_ctrl #(
        .TICK_DIV (10),
        .ADJ_DIV  (5),
        .BLINK_DIV(3),
        .SCAN_DIV (4),
        .DEB_LEN  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_pause(btn_pause),
        .btn_clr  (btn_clr),
        .sw_adj   (sw_adj),
        .sw_sel   (sw_sel),
        .run_inc_o(run_inc_o),
        .adj_sec_o(adj_sec_o),
        .adj_min_o(adj_min_o),
        .clr_o    (clr_o),
        .blink_on (blink_on),
        .blink_sel(blink_sel),
        .digit_sel(digit_sel),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic push(input int c, input logic [3:0] k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, and settle the strobe queue
    task automatic tick();
        logic [3:0] m;
        @(posedge clk);
        #1;
        cyc++;
        m = {clr_o, adj_min_o, adj_sec_o, run_inc_o};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_total++;
            $display("FAIL strobe_missing cyc=%0d got none required %b", sb[0].cyc, sb[0].kind);
            void'(sb.pop_front());
        end
        if (m !== 4'b0000) begin
            n_total++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                if (sb[0].kind === m) n_pass++;
                else $display("FAIL strobe_kind cyc=%0d got %b required %b", cyc, m, sb[0].kind);
                void'(sb.pop_front());
            end else begin
                $display("FAIL strobe_unexpected cyc=%0d got %b required 0000", cyc, m);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_pause = 1'b0; btn_clr = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({state_o, digit_sel, blink_on, blink_sel} !== 6'b000010)
                $display("FAIL reset_outputs got %b required 000010",
                         {state_o, digit_sel, blink_on, blink_sel});
            else n_pass++;
        end
        rst = 1'b0;
        r0  = cyc;
        push(r0 + 9, K_RUN);
        push(r0 + 19, K_RUN);
        push(r0 + 29, K_RUN);
    endtask

    task automatic test_run_scan();
        logic [1:0] exp_dg;
        while (cyc < r0 + 30) begin
            tick();
            exp_dg = 2'((cyc - r0) / 4);
            n_total++;
            if (digit_sel !== exp_dg) $display("FAIL scan_digit got %0d required %0d", digit_sel, exp_dg);
            else n_pass++;
            n_total++;
            if ({state_o, blink_on} !== {ST_R, 1'b1})
                $display("FAIL run_state_blink got %b required 001", {state_o, blink_on});
            else n_pass++;
        end
    endtask

    task automatic test_pause_glitch();
        int t0;
        t0 = cyc;
        push(t0 + 9, K_RUN);
        btn_pause = 1'b1;
        tick();
        tick();
        btn_pause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_total++;
            if (state_o !== ST_R) $display("FAIL glitch_state got %0d required %0d", state_o, ST_R);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        int t0;
        logic [1:0] exp_st;
        t0 = cyc;
        btn_pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cyc - t0 == 12) btn_pause = 1'b0;
            tick();
            exp_st = (cyc - t0 >= 7) ? ST_P : ST_R;
            n_total++;
            if (state_o !== exp_st) $display("FAIL pause_state got %0d required %0d", state_o, exp_st);
            else n_pass++;
        end
        // divider held at 7, so resuming needs 3 more cycles to finish that second
        t0 = cyc;
        push(t0 + 9, K_RUN);
        push(t0 + 19, K_RUN);
        btn_pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cyc - t0 == 8) btn_pause = 1'b0;
            tick();
            exp_st = (cyc - t0 >= 7) ? ST_R : ST_P;
            n_total++;
            if (state_o !== exp_st) $display("FAIL resume_state got %0d required %0d", state_o, exp_st);
            else n_pass++;
        end
    endtask

    task automatic test_adj();
        int t0, d;
        logic [1:0] exp_st;
        logic exp_bl, exp_sel;
        t0 = cyc;
        push(t0 + 7, K_SEC);
        push(t0 + 12, K_SEC);
        push(t0 + 17, K_SEC);
        push(t0 + 22, K_MIN);
        push(t0 + 27, K_MIN);
        push(t0 + 37, K_RUN);
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cyc - t0 == 18) sw_sel = 1'b0;
            if (cyc - t0 == 28) sw_adj = 1'b0;
            tick();
            d = cyc - t0;
            exp_st  = (d >= 3 && d <= 30) ? ST_A : ST_R;
            exp_bl  = (d >= 3 && d <= 30) ? (((d - 3) / 3) % 2 == 0) : 1'b1;
            exp_sel = (d >= 2 && d < 20);
            n_total++;
            if (state_o !== exp_st) $display("FAIL adj_state d=%0d got %0d required %0d", d, state_o, exp_st);
            else n_pass++;
            n_total++;
            if (blink_on !== exp_bl) $display("FAIL adj_blink d=%0d got %b required %b", d, blink_on, exp_bl);
            else n_pass++;
            n_total++;
            if (blink_sel !== exp_sel) $display("FAIL adj_sel d=%0d got %b required %b", d, blink_sel, exp_sel);
            else n_pass++;
        end
    endtask

    task automatic test_clr();
        int t0;
        // run divider sits at 2 here, so the clear lands on count 9
        t0 = cyc;
        push(t0 + 7, K_CLR);
        push(t0 + 17, K_RUN);
        push(t0 + 27, K_RUN);
        btn_clr = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (cyc - t0 == 8) btn_clr = 1'b0;
            tick();
            n_total++;
            if (state_o !== ST_R) $display("FAIL clr_state got %0d required %0d", state_o, ST_R);
            else n_pass++;
        end
    endtask

    task automatic test_adj_pause();
        int t0, d;
        logic [1:0] exp_st;
        t0 = cyc;
        push(t0 + 7, K_SEC);
        push(t0 + 12, K_SEC);
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cyc - t0 == 4) btn_pause = 1'b1;
            if (cyc - t0 == 12) btn_pause = 1'b0;
            if (cyc - t0 == 13) sw_adj = 1'b0;
            tick();
            d = cyc - t0;
            exp_st = (d < 3) ? ST_R : ((d < 16) ? ST_A : ST_P);
            n_total++;
            if (state_o !== exp_st) $display("FAIL adjpause_state d=%0d got %0d required %0d", d, state_o, exp_st);
            else n_pass++;
        end
    endtask

    task automatic test_rst_adj();
        int t0, d;
        t0 = cyc;
        push(t0 + 7, K_SEC);
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (cyc - t0 == 4) btn_pause = 1'b1;
            if (cyc - t0 == 7) begin
                rst = 1'b1; btn_pause = 1'b0; btn_clr = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
            end
            tick();
            d = cyc - t0;
            if (d >= 3 && d <= 7) begin
                n_total++;
                if (state_o !== ST_A) $display("FAIL rstadj_state d=%0d got %0d required %0d", d, state_o, ST_A);
                else n_pass++;
            end
            if (d >= 6 && d <= 7) begin
                n_total++;
                if (blink_on !== 1'b0) $display("FAIL rstadj_blink d=%0d got %b required 0", d, blink_on);
                else n_pass++;
            end
        end
        n_total++;
        if ({state_o, digit_sel, blink_on, blink_sel} !== 6'b000010)
            $display("FAIL rstadj_outputs got %b required 000010", {state_o, digit_sel, blink_on, blink_sel});
        else n_pass++;
        rst = 1'b0;
        r1  = cyc;
    endtask

    task automatic test_restart();
        logic [1:0] exp_dg;
        push(r1 + 9, K_RUN);
        push(r1 + 19, K_RUN);
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_dg = 2'((cyc - r1) / 4);
            n_total++;
            if (digit_sel !== exp_dg) $display("FAIL restart_digit got %0d required %0d", digit_sel, exp_dg);
            else n_pass++;
            n_total++;
            if (state_o !== ST_R) $display("FAIL restart_state got %0d required %0d", state_o, ST_R);
            else n_pass++;
        end
        tick();
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run_scan();
        test_pause_glitch();
        test_pause();
        test_adj();
        test_clr();
        test_adj_pause();
        test_rst_adj();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
